// File: rtl/sm83_irq_ctrl_if.sv
// sm83_irq_ctrl_if: bus bundle between the SM83 sequencer/peripherals and
// the interrupt controller. The master side drives triggers, register
// accesses and IME/dispatch strobes; the slave side (the controller)
// returns read data, request, wake, vector and acknowledge.
interface sm83_irq_ctrl_if #(
  parameter int NUM_IRQ = 5
);
  logic [NUM_IRQ-1:0] CPU_IRQ_TRIG;
  logic               REG_SEL;
  logic               REG_WR;
  logic [7:0]         DL;
  logic [7:0]         DV;
  logic               IME_SET;
  logic               IME_CLR;
  logic               LoadIR;
  logic               IRQ_ACK_REQ;
  logic               IRQ_REQ;
  logic               WAKE;
  logic [7:0]         VECTOR;
  logic [NUM_IRQ-1:0] CPU_IRQ_ACK;

  modport master (
    output CPU_IRQ_TRIG, REG_SEL, REG_WR, DL, IME_SET, IME_CLR, LoadIR, IRQ_ACK_REQ,
    input  DV, IRQ_REQ, WAKE, VECTOR, CPU_IRQ_ACK
  );

  modport slave (
    input  CPU_IRQ_TRIG, REG_SEL, REG_WR, DL, IME_SET, IME_CLR, LoadIR, IRQ_ACK_REQ,
    output DV, IRQ_REQ, WAKE, VECTOR, CPU_IRQ_ACK
  );
endinterface

// File: rtl/sm83_irq_ctrl.sv
// sm83_irq_ctrl: parametrised SM83 interrupt controller. Owns IF, IE, IME
// (with the one-instruction EI delay), the lowest-index priority pick,
// vector generation, the one-cycle acknowledge pulse and HALT wake.
//
// Build option: define SM83_IRQ_EDGE_DETECT_EN to make trigger lines
// edge-sensitive (0->1 against a registered history). Without it the
// lines are level-sensitive and no history register exists.
module sm83_irq_ctrl #(
  parameter int         NUM_IRQ    = 5,      // 1..8 channels
  parameter logic [7:0] VEC_BASE   = 8'h40,
  parameter logic [7:0] VEC_STRIDE = 8'd8
) (
  input logic            CLK,
  input logic            SYNC_RESET,
  sm83_irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISPATCH
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q;
  logic               ime_q, ime_d;
  logic               ime_pend_q, ime_pend_d;
  logic [7:0]         vector_q, vector_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;

  logic [NUM_IRQ-1:0] trig_event;
  logic [NUM_IRQ-1:0] pending;
  logic               win_found;
  logic [2:0]         win_idx;
  logic [NUM_IRQ-1:0] win_onehot;
  logic               take;       // dispatch accepted this cycle
  logic               win_valid;  // dispatch accepted and a channel wins
  logic [7:0]         dv_if;

`ifdef SM83_IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] hist_q;

  // Trigger history; cleared by reset so a line high at release fires once.
  always_ff @(posedge CLK) begin
    if (SYNC_RESET) hist_q <= '0;
    else            hist_q <= bus.CPU_IRQ_TRIG;
  end

  assign trig_event = bus.CPU_IRQ_TRIG & ~hist_q;
`else
  assign trig_event = bus.CPU_IRQ_TRIG;
`endif

  assign pending = if_q & ie_q[NUM_IRQ-1:0];

  // Lowest set index of IF&IE wins; scanning downward leaves the lowest.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end

  assign win_onehot = NUM_IRQ'(1) << win_idx;
  assign take       = bus.IRQ_ACK_REQ && (state_q != ST_DISPATCH);
  // A dispatch accepted from IDLE has no winner even if IF&IE is set.
  assign win_valid  = bus.IRQ_ACK_REQ && (state_q == ST_REQ) && win_found;

  // Next-state logic for the request/dispatch sequencer handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.IRQ_ACK_REQ)          state_d = ST_DISPATCH;
        else if (ime_q && win_found)  state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.IRQ_ACK_REQ)          state_d = ST_DISPATCH;
        else if (!(ime_q && win_found)) state_d = ST_IDLE;
      end
      ST_DISPATCH:                    state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // IF update order: software write, then dispatch clear, then trigger set
  // so a new event always survives a same-cycle clear.
  always_comb begin
    if_d = if_q;
    if (bus.REG_WR && !bus.REG_SEL) if_d = bus.DL[NUM_IRQ-1:0];
    if (win_valid)                  if_d = if_d & ~win_onehot;
    if_d = if_d | trig_event;
  end

  // IME with EI delay: a pending EI is promoted only by a LoadIR that sees
  // it already pending; DI and dispatch both drop IME and the pending EI.
  always_comb begin
    ime_d      = ime_q;
    ime_pend_d = ime_pend_q;
    if (bus.LoadIR && ime_pend_q) begin
      ime_d      = 1'b1;
      ime_pend_d = 1'b0;
    end
    if (bus.IME_SET) ime_pend_d = 1'b1;
    if (bus.IME_CLR || take) begin
      ime_d      = 1'b0;
      ime_pend_d = 1'b0;
    end
  end

  // Vector and acknowledge are captured on the dispatch edge; the vector
  // then holds until the next dispatch, the acknowledge lasts one cycle.
  always_comb begin
    vector_d = vector_q;
    ack_d    = '0;
    if (take) vector_d = win_valid ? 8'(VEC_BASE + ({5'b0, win_idx} * VEC_STRIDE)) : 8'h00;
    if (win_valid) ack_d = win_onehot;
  end

  // Architectural state registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (SYNC_RESET) begin
      state_q    <= ST_IDLE;
      if_q       <= '0;
      ie_q       <= 8'h00;
      ime_q      <= 1'b0;
      ime_pend_q <= 1'b0;
      vector_q   <= 8'h00;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      if_q       <= if_d;
      if (bus.REG_WR && bus.REG_SEL) ie_q <= bus.DL;
      ime_q      <= ime_d;
      ime_pend_q <= ime_pend_d;
      vector_q   <= vector_d;
      ack_q      <= ack_d;
    end
  end

  // IF reads back with the unimplemented upper bits forced high.
  always_comb begin
    dv_if              = 8'hFF;
    dv_if[NUM_IRQ-1:0] = if_q;
  end

  assign bus.DV          = bus.REG_SEL ? ie_q : dv_if;
  assign bus.IRQ_REQ     = (state_q == ST_REQ);
  assign bus.WAKE        = |pending;
  assign bus.VECTOR      = vector_q;
  assign bus.CPU_IRQ_ACK = ack_q;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// tb_sm83_irq_ctrl: scoreboard bench. The driver applies one input set per
// cycle at the falling edge, advances a rule-level reference model and
// queues the expected post-edge outputs; the monitor pops and compares
// shortly after every rising edge.
module tb_sm83_irq_ctrl;

  localparam int         N  = 5;
  localparam logic [7:0] VB = 8'h40;
  localparam int         VS = 8;

  typedef struct {
    logic         rst;
    logic [N-1:0] trig;
    logic         sel;
    logic         wr;
    logic [7:0]   dl;
    logic         ime_set;
    logic         ime_clr;
    logic         load_ir;
    logic         ack;
  } stim_t;

  typedef struct {
    logic         irq_req;
    logic         wake;
    logic [7:0]   vector;
    logic [N-1:0] cpu_ack;
    logic [7:0]   dv;
  } exp_t;

  logic clk = 1'b0;
  logic sync_reset;
  always #5 clk = ~clk;

  sm83_irq_ctrl_if #(.NUM_IRQ(N)) bus ();

  sm83_irq_ctrl #(.NUM_IRQ(N), .VEC_BASE(VB), .VEC_STRIDE(8'(VS))) dut (
    .CLK       (clk),
    .SYNC_RESET(sync_reset),
    .bus       (bus)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state, kept as the architectural facts: IF, IE, IME,
  // pending EI, "request raised", "last cycle was a dispatch", outputs.
  logic [N-1:0] m_if, m_hist, m_ack;
  logic [7:0]   m_ie, m_vec;
  logic         m_ime, m_pend, m_req, m_disp;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.trig = '0; s.sel = 1'b0; s.wr = 1'b0; s.dl = 8'h00;
    s.ime_set = 1'b0; s.ime_clr = 1'b0; s.load_ir = 1'b0; s.ack = 1'b0;
    return s;
  endfunction

  // One clock of the specification's rules.
  task automatic model_step(input stim_t s, output exp_t e);
    logic [N-1:0] pend_bits, events, nif;
    logic         take, win;
    int           idx;
    if (s.rst) begin
      m_if = '0; m_ie = 8'h00; m_ime = 1'b0; m_pend = 1'b0; m_req = 1'b0;
      m_disp = 1'b0; m_hist = '0; m_vec = 8'h00; m_ack = '0;
    end else begin
      pend_bits = m_if & m_ie[N-1:0];
      take = s.ack && !m_disp;
      win  = take && m_req && (pend_bits != 0);
      idx  = 0;
      while (idx < N - 1 && !pend_bits[idx]) idx++;
`ifdef SM83_IRQ_EDGE_DETECT_EN
      events = s.trig & ~m_hist;
`else
      events = s.trig;
`endif
      nif = m_if;
      if (s.wr && !s.sel) nif = s.dl[N-1:0];
      if (win) nif[idx] = 1'b0;
      nif = nif | events;
      // Request is held exactly while IME and a pending channel exist,
      // except around a dispatch.
      m_req = !take && !m_disp && m_ime && (pend_bits != 0);
      if (take) m_vec = win ? 8'((int'(VB) + idx * VS) % 256) : 8'h00;
      m_ack = win ? N'(1 << idx) : '0;
      m_disp = take;
      if (s.load_ir && m_pend) begin m_ime = 1'b1; m_pend = 1'b0; end
      if (s.ime_set) m_pend = 1'b1;
      if (s.ime_clr || take) begin m_ime = 1'b0; m_pend = 1'b0; end
      if (s.wr && s.sel) m_ie = s.dl;
      m_if   = nif;
      m_hist = s.trig;
    end
    e.irq_req = m_req;
    e.wake    = (m_if & m_ie[N-1:0]) != 0;
    e.vector  = m_vec;
    e.cpu_ack = m_ack;
    e.dv      = 8'hFF;
    e.dv[N-1:0] = m_if;
    if (s.sel) e.dv = m_ie;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    sync_reset           = s.rst;
    bus.CPU_IRQ_TRIG     = s.trig;
    bus.REG_SEL          = s.sel;
    bus.REG_WR           = s.wr;
    bus.DL               = s.dl;
    bus.IME_SET          = s.ime_set;
    bus.IME_CLR          = s.ime_clr;
    bus.LoadIR           = s.load_ir;
    bus.IRQ_ACK_REQ      = s.ack;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask

  task automatic write_reg(input logic sel, input logic [7:0] data, input logic [N-1:0] trig);
    stim_t s = idle();
    s.wr = 1'b1; s.sel = sel; s.dl = data; s.trig = trig;
    step(s);
  endtask

  task automatic enable_ime();
    stim_t s = idle();
    s.ime_set = 1'b1; step(s);
    s = idle(); s.load_ir = 1'b1; step(s);
  endtask

  task automatic pulse(input logic [N-1:0] trig, input logic ack);
    stim_t s = idle();
    s.trig = trig; s.ack = ack;
    step(s);
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("IRQ_REQ",     32'(bus.IRQ_REQ),     32'(e.irq_req));
        check("WAKE",        32'(bus.WAKE),        32'(e.wake));
        check("VECTOR",      32'(bus.VECTOR),      32'(e.vector));
        check("CPU_IRQ_ACK", 32'(bus.CPU_IRQ_ACK), 32'(e.cpu_ack));
        check("DV",          32'(bus.DV),          32'(e.dv));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    // Reset with every line high, then release with lines still high.
    s = idle(); s.rst = 1'b1; s.trig = '1;
    step(s); step(s);
    s = idle(); s.trig = '1; step(s);
    idles(1);
    write_reg(1'b0, 8'h00, '0);
    write_reg(1'b1, 8'h1F, '0);

    // Priority pick: channels 2 and 0 together, channel 0 wins.
    enable_ime();
    pulse(5'b00101, 1'b0);
    idles(2);
    pulse('0, 1'b1);
    idles(2);
    enable_ime();
    idles(3);
    pulse('0, 1'b1);
    idles(2);

    // EI delay: pending interrupt, EI without LoadIR holds off the request.
    pulse(5'b10000, 1'b0);
    s = idle(); s.ime_set = 1'b1; step(s);
    idles(3);
    s = idle(); s.load_ir = 1'b1; step(s);
    idles(2);
    pulse('0, 1'b1);
    idles(1);

    // EI and LoadIR in the same cycle do not promote; the next LoadIR does.
    pulse(5'b01000, 1'b0);
    s = idle(); s.ime_set = 1'b1; s.load_ir = 1'b1; step(s);
    idles(2);
    s = idle(); s.load_ir = 1'b1; step(s);
    idles(2);
    pulse('0, 1'b1);
    idles(1);

    // Cancellation: clear IF while requesting, then a late acknowledge.
    pulse(5'b00010, 1'b0);
    enable_ime();
    idles(2);
    write_reg(1'b0, 8'h00, '0);
    idles(2);
    pulse('0, 1'b1);
    idles(2);

    // Collision: dispatch of channel 1 coincides with a new channel 1 event.
    pulse(5'b00010, 1'b0);
    idles(1);
    enable_ime();
    idles(2);
    pulse(5'b00010, 1'b1);
    idles(2);
    write_reg(1'b0, 8'h00, '0);

    // Level vs edge: hold channel 3 high and clear IF underneath it.
    pulse(5'b01000, 1'b0);
    pulse(5'b01000, 1'b0);
    write_reg(1'b0, 8'h00, 5'b01000);
    pulse(5'b01000, 1'b0);
    pulse(5'b01000, 1'b0);
    write_reg(1'b0, 8'h00, '0);
    idles(1);

    // IF write coinciding with dispatch: write applies, then winner clears.
    pulse(5'b00100, 1'b0);
    enable_ime();
    idles(2);
    s = idle(); s.ack = 1'b1; s.wr = 1'b1; s.sel = 1'b0; s.dl = 8'h0C; step(s);
    idles(2);

    // Reset arriving right after an accepted dispatch.
    pulse(5'b00001, 1'b0);
    enable_ime();
    idles(2);
    pulse('0, 1'b1);
    s = idle(); s.rst = 1'b1; s.ack = 1'b1; step(s);
    idles(2);

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      s = idle();
      s.rst     = ($urandom_range(0, 299) == 0);
      s.trig    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      s.sel     = 1'($urandom_range(0, 1));
      s.wr      = ($urandom_range(0, 9) == 0);
      s.dl      = 8'($urandom);
      s.ime_set = ($urandom_range(0, 7) == 0);
      s.ime_clr = ($urandom_range(0, 29) == 0);
      s.load_ir = ($urandom_range(0, 2) == 0);
      s.ack     = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      step(s);
    end
    idles(1);

    @(posedge clk);
    #4;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sm83_irq_ctrl.md
# sm83_irq_ctrl

Parametrised interrupt controller for the SM83 core. It replaces the fixed 8-bit CPU_IRQ_TRIG/CPU_IRQ_ACK path with a configurable channel count and owns the IF, IE and IME state. It also owns the EI delay, the priority pick, vector generation, the one-cycle acknowledge pulse and HALT wake. It sits between the peripheral trigger lines and the sequencer, and exchanges register data over the DL/DV buses.

## Interface
- NUM_IRQ, 5: number of interrupt channels; legal range 1..8.
- VEC_BASE, 8'h40: vector of channel 0.
- VEC_STRIDE, 8: vector spacing; VECTOR = VEC_BASE + idx*VEC_STRIDE, truncated to 8 bits.

- CLK  in  1  core clock; all state updates on rising edge.
- SYNC_RESET  in  1  reset, synchronous, active-high.
- CPU_IRQ_TRIG  in  NUM_IRQ  peripheral request lines.
- REG_SEL  in  1  register select: 0 = IF, 1 = IE.
- REG_WR  in  1  write DL into the selected register.
- DL  in  8  write data.
- DV  out  8  read data of the selected register; combinational.
- IME_SET  in  1  EI pulse.
- IME_CLR  in  1  DI pulse.
- LoadIR  in  1  opcode-fetch strobe; promotes a pending EI.
- IRQ_ACK_REQ  in  1  sequencer accepts dispatch; one-cycle pulse.
- IRQ_REQ  out  1  interrupt request to the sequencer.
- WAKE  out  1  HALT wake; (IF & IE[NUM_IRQ-1:0]) != 0, independent of IME.
- VECTOR  out  8  dispatch vector; held until the next dispatch.
- CPU_IRQ_ACK  out  NUM_IRQ  one-hot acknowledge; one cycle wide.

## Operation
- **IF register (NUM_IRQ bits).** A bit is set by a trigger event, cleared by an IF write, and cleared by dispatch of that channel.
- **IF read.** Bits NUM_IRQ..7 read as 1.
- **IE register.** Full 8-bit storage; all 8 bits read back.
- **Priority.** Only IE[NUM_IRQ-1:0] participates; the lowest set index of IF&IE wins.
- **IME.**
  - IME_SET sets ime_pend.
  - On a LoadIR cycle with ime_pend=1: IME=1, ime_pend=0.
  - IME_CLR clears both IME and ime_pend, and wins over a simultaneous IME_SET.
- **State machine.**
  - IDLE → REQ when IME & (IF&IE) != 0.
  - REQ → IDLE when IME=0 or IF&IE becomes 0 (request cancelled).
  - REQ with IRQ_ACK_REQ → DISPATCH.
  - IDLE with IRQ_ACK_REQ → DISPATCH with no winner.
  - DISPATCH → IDLE unconditionally.
- **IRQ_REQ** = (state == REQ).
- **Dispatch cycle** (the cycle in which IRQ_ACK_REQ is sampled; the winner is re-evaluated at that cycle, not frozen at REQ entry):
  - Winner present: VECTOR = base + idx*stride, clear IF[idx], pulse CPU_IRQ_ACK[idx] in DISPATCH.
  - No winner: VECTOR = 8'h00, CPU_IRQ_ACK stays 0.
  - In both cases IME=0 and ime_pend=0.
- **Collisions.**
  - A trigger event beats an IF write-clear or a dispatch clear on the same bit in the same cycle; the bit ends at 1.
  - REG_WR to IF in the same cycle as a dispatch: the write applies, then the dispatch clear of the winner bit applies.

## Timing
- **Trigger to outputs.** Trigger event sampled at edge n → IF bit visible after edge n → WAKE high in the same cycle (combinational).
- **Request latency.** With IME=1: state=REQ after edge n+1, so IRQ_REQ rises 1 cycle after IF.
- **Acknowledge.** IRQ_ACK_REQ sampled at edge m → DISPATCH, CPU_IRQ_ACK pulse and new VECTOR visible during cycle m+1. IF clear is visible at m+1, and IRQ_REQ=0 at m+1.
- **EI delay.** EI takes effect only at the first LoadIR after IME_SET. An IME_SET and a LoadIR in the same cycle do not promote; the next LoadIR does.
- **Reset values.** IF=0, IE=0, IME=0, ime_pend=0, edge history=0, state=IDLE, IRQ_REQ=0, WAKE=0, VECTOR=8'h00, CPU_IRQ_ACK=0.
- **Reset priority.** Reset overrides every other input, including mid-DISPATCH; no ACK pulse is emitted in the reset cycle or the cycle after it.

## Configuration
- **Macro: SM83_IRQ_EDGE_DETECT_EN.**
- **Defined:** a trigger event is a 0→1 transition of CPU_IRQ_TRIG[i] against a registered history. A line held high sets IF once; after software clears IF it stays clear.
- **Undefined:** level mode; IF[i] is set every cycle CPU_IRQ_TRIG[i]=1. The history register is not built.
- **Edge detect after reset:** the history resets to 0, so a line high at reset release produces one event.

## Test plan
- **Reset:** assert SYNC_RESET for 2 cycles with CPU_IRQ_TRIG=all 1 → all outputs at reset values; DV=8'hE0 for IF with NUM_IRQ=5.
- **Priority pick:** IE=8'h1F, IME promoted via IME_SET then LoadIR, pulse TRIG[2] and TRIG[0] together, ack → VECTOR=8'h40, CPU_IRQ_ACK=5'b00001, IF=5'b00100, IRQ_REQ re-rises 1 cycle after IME is set again.
- **EI delay:** IME_SET with IF&IE pending, no LoadIR → IRQ_REQ stays 0; LoadIR → IRQ_REQ=1 one cycle later.
- **Cancellation:** in REQ, write IF=0 → IRQ_REQ=0 next cycle; a subsequent IRQ_ACK_REQ → VECTOR=8'h00, CPU_IRQ_ACK=0, IME=0.
- **Collision:** dispatch clear of IF[1] coinciding with a new TRIG[1] event → IF[1]=1 after DISPATCH and CPU_IRQ_ACK[1] pulsed once.
- **Level vs edge:** hold TRIG[3] high, clear IF[3] by write → with SM83_IRQ_EDGE_DETECT_EN, IF[3] stays 0; without it, IF[3]=1 next cycle.
